decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with ports named as follows:
  - i_clk  in  1  clock; all state updates on rising edge
  - i_rst_n  in  1  asynchronous reset, active low
REQ-002 The remaining ports SHALL be:
  - i_fetch_pc  in  32  PC of fetched instruction
  - i_fetch_instr  in  32  fetched instruction word
  - i_flush  in  1  taken branch/jump from execute; squash IF/ID
  - i_ex_memRead  in  1  instruction now in execute is a load
  - i_ex_rt  in  5  destination of that load
  - i_wb_regWrite  in  1  write-back enable
  - i_wb_addr  in  5  write-back register
  - i_wb_data  in  32  write-back data
  - o_pcWrite  out  1  PC/IF-ID update enable (0 = stall)
  - o_id_pc  out  32  PC of decoded instruction
  - o_id_rs_data  out  32  register read, port A
  - o_id_rt_data  out  32  register read, port B
  - o_id_imm  out  32  sign-extended instr[15:0]
  - o_id_rs, o_id_rt, o_id_rd  out  5 each  instr[25:21], [20:16], [15:11]
  - o_id_ctrl  out  9  {regWrite, memRead, memWrite, branch, aluSrc, regDst, memToReg, aluOp[1:0]}

Function
REQ-003 The IF/ID register SHALL hold pc and instr. On each edge:
  - i_flush=1: load instr=0 (NOP), pc=0.
  - Else stall=1: hold.
  - Else: load i_fetch_pc and i_fetch_instr.
  - i_flush SHALL take priority over stall.
REQ-004 stall SHALL be i_ex_memRead AND i_ex_rt!=0 AND (IF/ID rs==i_ex_rt OR IF/ID rt==i_ex_rt); it is combinational.
REQ-005 o_pcWrite SHALL be NOT stall, combinationally.
REQ-006 The register file SHALL be 32x32 with two combinational read ports, addressed by IF/ID rs and rt.
REQ-007 Register 0 SHALL always read 0 and SHALL ignore writes.
REQ-008 A write SHALL occur on the edge when i_wb_regWrite=1 and i_wb_addr!=0.
REQ-009 Same-cycle bypass: when a write is pending to a nonzero address equal to a read address, that port SHALL return i_wb_data.
REQ-010 Control decode by opcode instr[31:26] (bit order as in REQ-002):
  - 000000 R-type: 1,0,0,0,0,1,0,10
  - 100011 lw: 1,1,0,0,1,0,1,00
  - 101011 sw: 0,0,1,0,1,0,0,00
  - 000100 beq: 0,0,0,1,0,0,0,01
  - 001000 addi: 1,0,0,0,1,0,0,00
  - any other opcode: all zero
REQ-011 All o_id_* outputs SHALL be registered in an ID/EX register, updated every edge.
REQ-012 The ID/EX register SHALL load a bubble when stall=1 or i_flush=1: o_id_ctrl=0. Datapath fields SHALL still load.
REQ-013 Latency: an instruction accepted into IF/ID at edge N SHALL appear on o_id_* after edge N+1, absent stall or flush.
REQ-014 A stall SHALL last exactly one cycle per load-use pair, because the load leaves execute.
REQ-015 Instruction 0x00000000 SHALL decode as R-type with rd=0; its register write is harmless because of REQ-007.

Reset
REQ-016 While i_rst_n=0, the IF/ID register, the ID/EX register and all 32 registers SHALL be cleared to 0.
REQ-017 Consequently, all o_id_* outputs SHALL read 0 during reset, and o_pcWrite SHALL read 1.
REQ-018 Reset asserted mid-stall SHALL clear all state immediately.
REQ-019 Reset takes effect asynchronously; the first edge after release SHALL perform a normal load.

Verification
REQ-020 Reset:
  - Stimulus: i_rst_n pulsed low.
  - Response: all outputs 0, o_pcWrite=1; after release, all 32 registers read 0.
REQ-021 Write-back and bypass:
  - Stimulus: write r5=0xDEADBEEF, then instr add r3,r5,r5 (0x00A51820).
  - Response: o_id_rs_data = o_id_rt_data = 0xDEADBEEF; o_id_ctrl=9'b100001010.
  - Same-cycle bypass case: write and read in the same cycle gives the same result.
REQ-022 Load-use stall:
  - Stimulus: i_ex_memRead=1, i_ex_rt=8, IF/ID holds an instr with rs=8.
  - Response: o_pcWrite=0 for one cycle; IF/ID held; next o_id_ctrl=0; then a normal decode.
REQ-023 Flush priority:
  - Stimulus: i_flush=1 together with stall=1.
  - Response: IF/ID becomes 0; o_id_ctrl=0 on the next two edges.
REQ-024 r0 and unknown opcode:
  - Stimulus: write r0=0xFFFFFFFF.
  - Response: r0 reads 0.
  - Stimulus: opcode 111111.
  - Response: o_id_ctrl=0; o_id_imm sign-extends 0x8000 to 0xFFFF8000.

Source files
------------

// File: rtl/decode.sv
// decode: IF/ID register, load-use hazard stall, 32x32 register file with write-back bypass, control decode and ID/EX register.
// Ports:
//   i_clk, i_rst_n            clock and asynchronous active-low reset
//   i_fetch_pc/instr          instruction arriving from fetch
//   i_flush                   squash IF/ID and bubble ID/EX (taken branch/jump)
//   i_ex_memRead, i_ex_rt     load currently in execute, for hazard detection
//   i_wb_regWrite/addr/data   register file write-back port
//   o_pcWrite                 0 while stalling on a load-use hazard
//   o_id_*                    registered ID/EX outputs
module decode (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_fetch_pc,
    input  logic [31:0] i_fetch_instr,
    input  logic        i_flush,
    input  logic        i_ex_memRead,
    input  logic [4:0]  i_ex_rt,
    input  logic        i_wb_regWrite,
    input  logic [4:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_pcWrite,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_rs_data,
    output logic [31:0] o_id_rt_data,
    output logic [31:0] o_id_imm,
    output logic [4:0]  o_id_rs,
    output logic [4:0]  o_id_rt,
    output logic [4:0]  o_id_rd,
    output logic [8:0]  o_id_ctrl
);
    logic [31:0] ifid_pc, ifid_instr;
    logic [31:0] regs [32];
    logic [4:0]  rs, rt;
    logic [5:0]  opcode;
    logic        stall, wb_en;
    logic [8:0]  ctrl;
    logic [31:0] rs_data, rt_data;

    assign rs        = ifid_instr[25:21];
    assign rt        = ifid_instr[20:16];
    assign opcode    = ifid_instr[31:26];
    assign stall     = i_ex_memRead && i_ex_rt != 5'd0 && (rs == i_ex_rt || rt == i_ex_rt);
    assign o_pcWrite = !stall;
    assign wb_en     = i_wb_regWrite && i_wb_addr != 5'd0;
    // Bypass lets an instruction read a value being written back on the same edge.
    assign rs_data   = rs == 5'd0 ? 32'd0 : (wb_en && i_wb_addr == rs) ? i_wb_data : regs[rs];
    assign rt_data   = rt == 5'd0 ? 32'd0 : (wb_en && i_wb_addr == rt) ? i_wb_data : regs[rt];

    // {regWrite, memRead, memWrite, branch, aluSrc, regDst, memToReg, aluOp[1:0]}
    always_comb begin
        ctrl = opcode == 6'b000000 ? 9'b100001010 :
               opcode == 6'b100011 ? 9'b110010100 :
               opcode == 6'b101011 ? 9'b001010000 :
               opcode == 6'b000100 ? 9'b000100001 :
               opcode == 6'b001000 ? 9'b100010000 : 9'b000000000;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ifid_pc      <= 32'd0;
            ifid_instr   <= 32'd0;
            o_id_pc      <= 32'd0;
            o_id_rs_data <= 32'd0;
            o_id_rt_data <= 32'd0;
            o_id_imm     <= 32'd0;
            o_id_rs      <= 5'd0;
            o_id_rt      <= 5'd0;
            o_id_rd      <= 5'd0;
            o_id_ctrl    <= 9'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            if (i_flush) begin
                ifid_pc    <= 32'd0;
                ifid_instr <= 32'd0;
            end else if (!stall) begin
                ifid_pc    <= i_fetch_pc;
                ifid_instr <= i_fetch_instr;
            end
            if (wb_en) regs[i_wb_addr] <= i_wb_data;
            o_id_pc      <= ifid_pc;
            o_id_rs_data <= rs_data;
            o_id_rt_data <= rt_data;
            o_id_imm     <= {{16{ifid_instr[15]}}, ifid_instr[15:0]};
            o_id_rs      <= rs;
            o_id_rt      <= rt;
            o_id_rd      <= ifid_instr[15:11];
            o_id_ctrl    <= (stall || i_flush) ? 9'd0 : ctrl;
        end
    end
endmodule

// File: tb/tb_decode.sv
// tb_decode: directed self-checking bench for the decode stage.
module tb_decode;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_fetch_pc, i_fetch_instr;
    logic        i_flush, i_ex_memRead;
    logic [4:0]  i_ex_rt;
    logic        i_wb_regWrite;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_pcWrite;
    logic [31:0] o_id_pc, o_id_rs_data, o_id_rt_data, o_id_imm;
    logic [4:0]  o_id_rs, o_id_rt, o_id_rd;
    logic [8:0]  o_id_ctrl;
    int checks = 0;
    int errors = 0;

    localparam logic [8:0] C_R    = 9'b100001010;
    localparam logic [8:0] C_LW   = 9'b110010100;
    localparam logic [8:0] C_SW   = 9'b001010000;
    localparam logic [8:0] C_BEQ  = 9'b000100001;
    localparam logic [8:0] C_ADDI = 9'b100010000;

    decode dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_fetch_pc(i_fetch_pc), .i_fetch_instr(i_fetch_instr),
        .i_flush(i_flush), .i_ex_memRead(i_ex_memRead), .i_ex_rt(i_ex_rt),
        .i_wb_regWrite(i_wb_regWrite), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_pcWrite(o_pcWrite), .o_id_pc(o_id_pc), .o_id_rs_data(o_id_rs_data),
        .o_id_rt_data(o_id_rt_data), .o_id_imm(o_id_imm), .o_id_rs(o_id_rs),
        .o_id_rt(o_id_rt), .o_id_rd(o_id_rd), .o_id_ctrl(o_id_ctrl)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
        i_fetch_pc = pc;
        i_fetch_instr = instr;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc"}, o_id_pc, 32'd0);
        check({tag, "_rsd"}, o_id_rs_data, 32'd0);
        check({tag, "_rtd"}, o_id_rt_data, 32'd0);
        check({tag, "_imm"}, o_id_imm, 32'd0);
        check({tag, "_fields"}, {17'd0, o_id_rs, o_id_rt, o_id_rd}, 32'd0);
        check({tag, "_ctrl"}, {23'd0, o_id_ctrl}, 32'd0);
        check({tag, "_pcw"}, {31'd0, o_pcWrite}, 32'd1);
    endtask

    initial begin
        i_rst_n = 1'b0;
        fetch(32'h0000_0040, rtype(5'd1, 5'd2, 5'd3));
        i_flush = 0; i_ex_memRead = 0; i_ex_rt = 0;
        i_wb_regWrite = 0; i_wb_addr = 0; i_wb_data = 0;
        step(); step();
        check_all_zero("reset");

        // First edge after release performs a normal load; every register reads 0.
        i_rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            fetch(32'h1000 + 32'(i * 4), rtype(5'(i), 5'(31 - i), 5'd0));
            step(); step();
            check("regs_rs_zero", o_id_rs_data, 32'd0);
            check("regs_rt_zero", o_id_rt_data, 32'd0);
        end
        check("reset_first_load_pc", o_id_pc, 32'h1000 + 32'(31 * 4));

        // Write r5, then add r3,r5,r5.
        fetch(32'h0, 32'h0);
        i_wb_regWrite = 1; i_wb_addr = 5'd5; i_wb_data = 32'hDEADBEEF;
        step();
        i_wb_regWrite = 0;
        fetch(32'h0000_0080, 32'h00A51820);
        step(); step();
        check("add_rs_data", o_id_rs_data, 32'hDEADBEEF);
        check("add_rt_data", o_id_rt_data, 32'hDEADBEEF);
        check("add_ctrl", {23'd0, o_id_ctrl}, {23'd0, C_R});
        check("add_pc", o_id_pc, 32'h0000_0080);
        check("add_fields", {17'd0, o_id_rs, o_id_rt, o_id_rd}, {17'd0, 5'd5, 5'd5, 5'd3});

        // Same-cycle bypass: r6 written on the very edge that ID/EX captures its read.
        fetch(32'h0000_0084, rtype(5'd6, 5'd6, 5'd6));
        step();
        i_wb_regWrite = 1; i_wb_addr = 5'd6; i_wb_data = 32'h12345678;
        step();
        i_wb_regWrite = 0;
        check("bypass_rs", o_id_rs_data, 32'h12345678);
        check("bypass_rt", o_id_rt_data, 32'h12345678);
        step();
        check("bypass_stored", o_id_rs_data, 32'h12345678);

        // r0 ignores writes and never bypasses.
        fetch(32'h0000_0088, rtype(5'd0, 5'd0, 5'd0));
        step();
        i_wb_regWrite = 1; i_wb_addr = 5'd0; i_wb_data = 32'hFFFFFFFF;
        step();
        i_wb_regWrite = 0;
        check("r0_bypass", o_id_rs_data, 32'd0);
        step();
        check("r0_stored", o_id_rt_data, 32'd0);
        check("nop_ctrl", {23'd0, o_id_ctrl}, {23'd0, C_R});

        // Unknown opcode and sign extension.
        fetch(32'h0000_0090, itype(6'b111111, 5'd1, 5'd2, 16'h8000));
        step(); step();
        check("unk_ctrl", {23'd0, o_id_ctrl}, 32'd0);
        check("unk_imm", o_id_imm, 32'hFFFF8000);
        check("unk_fields", {17'd0, o_id_rs, o_id_rt, o_id_rd}, {17'd0, 5'd1, 5'd2, 5'd16});

        // Remaining opcodes.
        fetch(32'h0000_00A0, itype(6'b100011, 5'd2, 5'd8, 16'h0004));
        step();
        fetch(32'h0000_00A4, itype(6'b101011, 5'd2, 5'd9, 16'h0008));
        step();
        check("lw_ctrl", {23'd0, o_id_ctrl}, {23'd0, C_LW});
        check("lw_imm", o_id_imm, 32'h0000_0004);
        fetch(32'h0000_00A8, itype(6'b000100, 5'd1, 5'd2, 16'hFFFE));
        step();
        check("sw_ctrl", {23'd0, o_id_ctrl}, {23'd0, C_SW});
        fetch(32'h0000_00AC, itype(6'b001000, 5'd1, 5'd2, 16'h7FFF));
        step();
        check("beq_ctrl", {23'd0, o_id_ctrl}, {23'd0, C_BEQ});
        check("beq_imm", o_id_imm, 32'hFFFF_FFFE);
        step();
        check("addi_ctrl", {23'd0, o_id_ctrl}, {23'd0, C_ADDI});
        check("addi_imm", o_id_imm, 32'h0000_7FFF);

        // Load-use stall: A reads r8 while a load to r8 is in execute.
        fetch(32'h0000_0100, rtype(5'd8, 5'd9, 5'd10));
        step();
        fetch(32'h0000_0104, itype(6'b001000, 5'd1, 5'd2, 16'h0001));
        i_ex_memRead = 1; i_ex_rt = 5'd8;
        #1;
        check("stall_pcw", {31'd0, o_pcWrite}, 32'd0);
        step();
        i_ex_memRead = 0;
        #1;
        check("stall_bubble", {23'd0, o_id_ctrl}, 32'd0);
        check("stall_pcw_back", {31'd0, o_pcWrite}, 32'd1);
        check("stall_bubble_pc", o_id_pc, 32'h0000_0100);
        step();
        check("stall_held_ctrl", {23'd0, o_id_ctrl}, {23'd0, C_R});
        check("stall_held_pc", o_id_pc, 32'h0000_0100);
        check("stall_held_rs", {27'd0, o_id_rs}, 32'd8);
        step();
        check("stall_next_ctrl", {23'd0, o_id_ctrl}, {23'd0, C_ADDI});
        check("stall_next_pc", o_id_pc, 32'h0000_0104);

        // Load to r0 never stalls.
        fetch(32'h0000_0108, rtype(5'd0, 5'd9, 5'd10));
        step();
        i_ex_memRead = 1; i_ex_rt = 5'd0;
        #1;
        check("r0_no_stall", {31'd0, o_pcWrite}, 32'd1);
        i_ex_memRead = 0;

        // Flush wins over stall.
        fetch(32'h0000_0200, rtype(5'd8, 5'd9, 5'd10));
        step();
        fetch(32'h0000_0204, itype(6'b001000, 5'd1, 5'd2, 16'h0001));
        i_ex_memRead = 1; i_ex_rt = 5'd8; i_flush = 1;
        #1;
        check("flush_stall_pcw", {31'd0, o_pcWrite}, 32'd0);
        step();
        i_ex_memRead = 0;
        check("flush_ctrl1", {23'd0, o_id_ctrl}, 32'd0);
        check("flush_pc1", o_id_pc, 32'h0000_0200);
        step();
        i_flush = 0;
        check("flush_ctrl2", {23'd0, o_id_ctrl}, 32'd0);
        check("flush_ifid_pc", o_id_pc, 32'd0);
        check("flush_ifid_fields", {17'd0, o_id_rs, o_id_rt, o_id_rd}, 32'd0);
        step(); step();
        check("after_flush_pc", o_id_pc, 32'h0000_0204);

        // Reset asserted mid-stall clears everything immediately.
        fetch(32'h0000_0300, rtype(5'd5, 5'd6, 5'd7));
        step();
        i_ex_memRead = 1; i_ex_rt = 5'd5;
        #1;
        check("pre_rst_pcw", {31'd0, o_pcWrite}, 32'd0);
        #1;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("midstall_rst");
        step();
        i_ex_memRead = 0;
        i_rst_n = 1'b1;
        step(); step();
        check("rst_r5_cleared", o_id_rs_data, 32'd0);
        check("rst_r6_cleared", o_id_rt_data, 32'd0);
        check("rst_reload_pc", o_id_pc, 32'h0000_0300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
